// File: rtl/mdu_controller_pkg.sv
// Shared definitions for the multiply/divide unit controller.
// Contents: 4-bit MDU operation codes, FSM state encodings, the
// operation classification helpers used by the controller, and the
// byte-lane parity helper that produces the even-parity bits of a
// 32-bit word.
package mdu_controller_pkg;

    // MDU operation codes carried by the E-stage instruction
    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'd7;
    localparam logic [3:0] MDU_MFLO  = 4'd8;

    // Controller states; BUSY is the only state in which the counter runs
    localparam logic MDU_IDLE = 1'b0;
    localparam logic MDU_BUSY = 1'b1;

    // True for the operations that occupy the unit for several cycles
    function automatic logic is_long_op(input logic [3:0] op);
        logic r;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the divide operations (they use the longer busy window)
    function automatic logic is_div_op(input logic [3:0] op);
        logic r;
        case (op)
            MDU_DIV, MDU_DIVU: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    // Even parity per byte lane of a 32-bit word
    function automatic logic [3:0] byte_parity(input logic [31:0] w);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op        in  4   MDU operation code
//   rs_value  in  32  first operand (multiplicand / dividend)
//   rt_value  in  32  second operand (multiplier / divisor)
//   hi        out 32  upper product word or remainder
//   lo        out 32  lower product word or quotient
//   valid     out 1   result should be committed (0 for divide by zero
//                     and for non-arithmetic ops)
module mdu_arith
    import mdu_controller_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        valid
);

    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic [31:0] divisor_s;
    logic [31:0] quot_signed_s;
    logic [31:0] rem_signed_s;
    logic [31:0] quot_unsigned_s;
    logic [31:0] rem_unsigned_s;
    logic        div_zero_s;
    logic        div_overflow_s;

    // Products and quotients for every operation, selected by op below
    always_comb begin
        prod_signed_s   = $signed({{32{rs_value[31]}}, rs_value}) *
                          $signed({{32{rt_value[31]}}, rt_value});
        prod_unsigned_s = {32'd0, rs_value} * {32'd0, rt_value};
        div_zero_s      = (rt_value == 32'd0);
        // Substitute a divisor of 1 so the dividers never see zero
        if (div_zero_s) begin
            divisor_s = 32'd1;
        end else begin
            divisor_s = rt_value;
        end
        // The most-negative / -1 case overflows; its result is pinned below
        div_overflow_s  = (rs_value == 32'h8000_0000) && (rt_value == 32'hFFFF_FFFF);
        quot_signed_s   = $signed(rs_value) / $signed(divisor_s);
        rem_signed_s    = $signed(rs_value) % $signed(divisor_s);
        quot_unsigned_s = rs_value / divisor_s;
        rem_unsigned_s  = rs_value % divisor_s;
    end

    // Result selection
    always_comb begin
        hi    = 32'd0;
        lo    = 32'd0;
        valid = 1'b0;
        case (op)
            MDU_MULT: begin
                hi    = prod_signed_s[63:32];
                lo    = prod_signed_s[31:0];
                valid = 1'b1;
            end
            MDU_MULTU: begin
                hi    = prod_unsigned_s[63:32];
                lo    = prod_unsigned_s[31:0];
                valid = 1'b1;
            end
            MDU_DIV: begin
                if (div_zero_s) begin
                    valid = 1'b0;
                end else if (div_overflow_s) begin
                    hi    = 32'd0;
                    lo    = 32'h8000_0000;
                    valid = 1'b1;
                end else begin
                    hi    = rem_signed_s;
                    lo    = quot_signed_s;
                    valid = 1'b1;
                end
            end
            MDU_DIVU: begin
                if (div_zero_s) begin
                    valid = 1'b0;
                end else begin
                    hi    = rem_unsigned_s;
                    lo    = quot_unsigned_s;
                    valid = 1'b1;
                end
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_controller.sv
// Multiply/divide unit controller for the E stage.
// Sequences multi-cycle mult/div with a countdown counter, owns HI/LO,
// serves mfhi/mflo to the E-stage result mux and requests a D-stage stall
// while the unit is occupied.
// Ports:
//   clk            in  1   system clock
//   reset          in  1   synchronous active-high reset
//   E_MDU_op       in  4   MDU operation in E (MDU_NONE otherwise)
//   E_rs_value     in  32  forwarded rs operand
//   E_rt_value     in  32  forwarded rt operand
//   D_is_MDU       in  1   D-stage instruction is an MDU op
//   E_MDU_result   out 32  HI for mfhi, LO for mflo, else 0
//   start          out 1   mult/div accepted this cycle
//   busy           out 1   operation counting down (state register)
//   stall_request  out 1   D_is_MDU && (start || busy)
//   HI, LO         out 32  architectural HI/LO registers
module mdu_controller
    import mdu_controller_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDU_op,
    input  logic [31:0] E_rs_value,
    input  logic [31:0] E_rt_value,
    input  logic        D_is_MDU,
    output logic [31:0] E_MDU_result,
    output logic        start,
    output logic        busy,
    output logic        stall_request,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic        state_r;
    logic        state_next_s;
    logic [3:0]  counter_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] pending_hi_r;
    logic [31:0] pending_lo_r;
    logic        pending_valid_r;
    logic        start_s;
    logic        last_cycle_s;
    logic [31:0] arith_hi_s;
    logic [31:0] arith_lo_s;
    logic        arith_valid_s;

    mdu_arith u_arith (
        .op       (E_MDU_op),
        .rs_value (E_rs_value),
        .rt_value (E_rt_value),
        .hi       (arith_hi_s),
        .lo       (arith_lo_s),
        .valid    (arith_valid_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MDU_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> BUSY on start, BUSY -> IDLE on the final count
    always_comb begin
        state_next_s = MDU_IDLE;
        case (state_r)
            MDU_IDLE: begin
                if (start_s) begin
                    state_next_s = MDU_BUSY;
                end else begin
                    state_next_s = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                if (last_cycle_s) begin
                    state_next_s = MDU_IDLE;
                end else begin
                    state_next_s = MDU_BUSY;
                end
            end
            default: begin
                state_next_s = MDU_IDLE;
            end
        endcase
    end

    // Output decode: start, result mux and stall request
    always_comb begin
        start_s       = (state_r == MDU_IDLE) && is_long_op(E_MDU_op);
        last_cycle_s  = (state_r == MDU_BUSY) && (counter_r == 4'd1);
        start         = start_s;
        stall_request = D_is_MDU && (start_s || (state_r == MDU_BUSY));
        case (E_MDU_op)
            MDU_MFHI: E_MDU_result = hi_r;
            MDU_MFLO: E_MDU_result = lo_r;
            MDU_NONE: E_MDU_result = 32'd0;
            default:  E_MDU_result = 32'd0;
        endcase
    end

    assign busy = (state_r == MDU_BUSY);
    assign HI   = hi_r;
    assign LO   = lo_r;

    // Counter, pending result and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_r       <= 4'd0;
            hi_r            <= 32'd0;
            lo_r            <= 32'd0;
            pending_hi_r    <= 32'd0;
            pending_lo_r    <= 32'd0;
            pending_valid_r <= 1'b0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    if (start_s) begin
                        counter_r       <= is_div_op(E_MDU_op) ? DIV_LOAD : MULT_LOAD;
                        pending_hi_r    <= arith_hi_s;
                        pending_lo_r    <= arith_lo_s;
                        pending_valid_r <= arith_valid_s;
                    end else if (E_MDU_op == MDU_MTHI) begin
                        hi_r <= E_rs_value;
                    end else if (E_MDU_op == MDU_MTLO) begin
                        lo_r <= E_rs_value;
                    end
                end
                MDU_BUSY: begin
                    // Ops arriving in E while busy are ignored here
                    counter_r <= counter_r - 4'd1;
                    if (last_cycle_s) begin
                        pending_valid_r <= 1'b0;
                        if (pending_valid_r) begin
                            hi_r <= pending_hi_r;
                            lo_r <= pending_lo_r;
                        end
                    end
                end
                default: begin
                    counter_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_controller.sv
// Self-checking bench for mdu_controller: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// timestamp-based reference model of HI/LO and the busy window.
module tb_mdu_controller;
    import mdu_controller_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDU_op;
    logic [31:0] E_rs_value;
    logic [31:0] E_rt_value;
    logic        D_is_MDU;
    logic [31:0] E_MDU_result;
    logic        start;
    logic        busy;
    logic        stall_request;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    mdu_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk           (clk),
        .reset         (reset),
        .E_MDU_op      (E_MDU_op),
        .E_rs_value    (E_rs_value),
        .E_rt_value    (E_rt_value),
        .D_is_MDU      (D_is_MDU),
        .E_MDU_result  (E_MDU_result),
        .start         (start),
        .busy          (busy),
        .stall_request (stall_request),
        .HI            (HI),
        .LO            (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An operation started in cycle T occupies the unit until the edge
    // ending cycle T+N, where its result (if any) lands in HI/LO.
    int          cyc = 0;
    logic        m_active = 1'b0;
    int          m_end = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    logic        m_pv = 1'b0;

    function automatic logic long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic void ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output logic v);
        longint      sp;
        longint      sq;
        longint      sr;
        logic [63:0] up;
        h = 32'd0; l = 32'd0; v = 1'b1;
        if (op == MDU_MULT) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            h = sp[63:32]; l = sp[31:0];
        end else if (op == MDU_MULTU) begin
            up = {32'd0, a} * {32'd0, b};
            h = up[63:32]; l = up[31:0];
        end else if (b == 32'd0) begin
            v = 1'b0;
        end else if (op == MDU_DIV) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            h = sr[31:0]; l = sq[31:0];
        end else begin
            h = a % b; l = a / b;
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] th;
        logic [31:0] tl;
        logic        tv;
        if (reset) begin
            m_active <= 1'b0;
            m_pv     <= 1'b0;
            m_hi     <= 32'd0;
            m_lo     <= 32'd0;
        end else if (m_active) begin
            if (cyc == m_end) begin
                m_active <= 1'b0;
                if (m_pv) begin
                    m_hi <= m_phi;
                    m_lo <= m_plo;
                end
            end
        end else if (long_op(E_MDU_op)) begin
            ref_calc(E_MDU_op, E_rs_value, E_rt_value, th, tl, tv);
            m_phi    <= th;
            m_plo    <= tl;
            m_pv     <= tv;
            m_active <= 1'b1;
            m_end    <= cyc + (((E_MDU_op == MDU_DIV) || (E_MDU_op == MDU_DIVU)) ? DC : MC);
        end else if (E_MDU_op == MDU_MTHI) begin
            m_hi <= E_rs_value;
        end else if (E_MDU_op == MDU_MTLO) begin
            m_lo <= E_rs_value;
        end
        cyc <= cyc + 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic        e_start;
        logic [31:0] e_res;
        if (chk_en) begin
            e_start = !m_active && long_op(E_MDU_op);
            e_res   = (E_MDU_op == MDU_MFHI) ? m_hi : (E_MDU_op == MDU_MFLO) ? m_lo : 32'd0;
            chk("start", {31'd0, start}, {31'd0, e_start});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("stall_request", {31'd0, stall_request}, {31'd0, D_is_MDU && (e_start || m_active)});
            chk("HI", HI, m_hi);
            chk("LO", LO, m_lo);
            chk("E_MDU_result", E_MDU_result, e_res);
            if (m_active) begin
                chk("no_mdu_op_while_busy", {28'd0, E_MDU_op}, {28'd0, MDU_NONE});
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic d, input int exp_n, input logic [31:0] ehi,
                         input logic [31:0] elo, input string nm);
        int n;
        int st;
        @(posedge clk); #1;
        E_MDU_op = op; E_rs_value = a; E_rt_value = b; D_is_MDU = d;
        #1;
        st = int'(stall_request);
        @(posedge clk); #1;
        E_MDU_op = MDU_NONE;
        n = 0;
        while (busy && n < 30) begin
            n++;
            st += int'(stall_request);
            @(posedge clk); #1;
        end
        chk({nm, "_busy_cycles"}, n, exp_n);
        chk({nm, "_stall_cycles"}, st, d ? exp_n + 1 : 0);
        chk({nm, "_stall_after"}, {31'd0, stall_request}, 32'd0);
        chk({nm, "_HI"}, HI, ehi);
        chk({nm, "_LO"}, LO, elo);
        D_is_MDU = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; E_MDU_op = MDU_NONE; E_rs_value = 32'd0; E_rt_value = 32'd0; D_is_MDU = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        // 1: reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_result", E_MDU_result, 32'd0);

        // 5: mthi/mfhi and mtlo/mflo back to back
        @(posedge clk); #1;
        E_MDU_op = MDU_MTHI; E_rs_value = 32'h1234_5678;
        @(posedge clk); #1;
        E_MDU_op = MDU_MFHI; E_rs_value = 32'd0;
        #1;
        chk("mfhi_result", E_MDU_result, 32'h1234_5678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        E_MDU_op = MDU_MTLO; E_rs_value = 32'hCAFE_F00D;
        @(posedge clk); #1;
        E_MDU_op = MDU_MFLO; E_rs_value = 32'd0;
        #1;
        chk("mflo_result", E_MDU_result, 32'hCAFE_F00D);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // 2 and 4: multiplies, with and without a dependent D instruction
        do_op(MDU_MULT,  32'hFFFF_FFFF, 32'd2, 1'b1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
        do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, MC, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        // 3: divides, divide by zero, overflow
        do_op(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        do_op(MDU_DIVU, 32'd7, 32'd0, 1'b0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu_by0");
        do_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, 32'd0, 32'h8000_0000, "div_ovf");
        do_op(MDU_DIVU, 32'd100, 32'd7, 1'b0, DC, 32'd2, 32'd14, "divu");

        // 6: reset during a divide
        @(posedge clk); #1;
        E_MDU_op = MDU_DIV; E_rs_value = 32'd100; E_rt_value = 32'd3;
        @(posedge clk); #1;
        E_MDU_op = MDU_NONE;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_HI", HI, 32'd0);
        chk("abort_LO", LO, 32'd0);
        repeat (8) begin @(posedge clk); #1; end
        chk("abort_late_HI", HI, 32'd0);
        chk("abort_late_LO", LO, 32'd0);

        // randomized traffic; new MDU ops only reach E while the unit is free
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            D_is_MDU   = 1'($urandom_range(0, 1));
            E_rs_value = pick();
            E_rt_value = pick();
            if (m_active || ($urandom_range(0, 3) == 0)) begin
                E_MDU_op = MDU_NONE;
            end else begin
                E_MDU_op = 4'($urandom_range(0, 8));
            end
        end
        @(posedge clk); #1;
        E_MDU_op = MDU_NONE;
        repeat (DC + 2) @(posedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
